// File: rtl/pianotiles_pkg.sv
// Shared Piano Tiles definitions: screen/colour widths, scheduler state encoding, pixel source select.
package pianotiles_pkg;

    localparam int SCREEN_X_W = 9;
    localparam int SCREEN_Y_W = 8;
    localparam int COLOR_W    = 3;
    localparam logic [COLOR_W-1:0] COL_WHITE = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_CLR_REL,
        ST_TILE,
        ST_TILE_REL,
        ST_DONE
    } sched_state_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_CLEAR,
        SRC_TILE
    } pix_src_t;

endpackage

// File: rtl/fds_pixel_mux.sv
// Registered 2:1 pixel selector feeding the single VGA adapter write port.
module fds_pixel_mux
    import pianotiles_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  pix_src_t              sel,
    input  logic [SCREEN_X_W-1:0] clr_x,
    input  logic [SCREEN_Y_W-1:0] clr_y,
    input  logic [COLOR_W-1:0]    clr_color,
    input  logic                  clr_en,
    input  logic [SCREEN_X_W-1:0] tl_x,
    input  logic [SCREEN_Y_W-1:0] tl_y,
    input  logic [COLOR_W-1:0]    tl_color,
    input  logic                  tl_en,
    output logic [SCREEN_X_W-1:0] vga_x,
    output logic [SCREEN_Y_W-1:0] vga_y,
    output logic [COLOR_W-1:0]    vga_color,
    output logic                  vga_plot
);

    // With no engine selected the coordinates hold and only the write strobe drops.
    always_ff @(posedge clock) begin
        if (reset) begin
            vga_x     <= '0;
            vga_y     <= '0;
            vga_color <= '0;
            vga_plot  <= 1'b0;
        end else begin
            case (sel)
                SRC_CLEAR: begin
                    vga_x     <= clr_x;
                    vga_y     <= clr_y;
                    vga_color <= clr_color;
                    vga_plot  <= clr_en;
                end
                SRC_TILE: begin
                    vga_x     <= tl_x;
                    vga_y     <= tl_y;
                    vga_color <= tl_color;
                    vga_plot  <= tl_en;
                end
                default: vga_plot <= 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/frame_draw_sched.sv
// Per-frame draw sequencer: screen clear, then one tile-engine pass per tile, owning the VGA write port.
// Define FDS_WATCHDOG_EN to add a per-pass cycle watchdog and the sticky wd_err output.
module frame_draw_sched
    import pianotiles_pkg::*;
#(
    parameter int NUM_TILES = 4,
    parameter int IDX_W     = 4,
    parameter int WD_CYCLES = 65536
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  frame_tick,
    output logic                  clear_go,
    input  logic                  clear_done,
    input  logic [SCREEN_X_W-1:0] clr_x,
    input  logic [SCREEN_Y_W-1:0] clr_y,
    input  logic [COLOR_W-1:0]    clr_color,
    input  logic                  clr_en,
    output logic                  tile_go,
    output logic [IDX_W-1:0]      tile_idx,
    input  logic                  tile_done,
    input  logic [SCREEN_X_W-1:0] tl_x,
    input  logic [SCREEN_Y_W-1:0] tl_y,
    input  logic [COLOR_W-1:0]    tl_color,
    input  logic                  tl_en,
    output logic [SCREEN_X_W-1:0] vga_x,
    output logic [SCREEN_Y_W-1:0] vga_y,
    output logic [COLOR_W-1:0]    vga_color,
    output logic                  vga_plot,
`ifdef FDS_WATCHDOG_EN
    output logic                  wd_err,
`endif
    output logic                  busy,
    output logic                  frame_done,
    output logic                  overrun
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TILES - 1);

    if (NUM_TILES < 1 || NUM_TILES > 16 || (1 << IDX_W) < NUM_TILES || WD_CYCLES < 1) begin : g_param_check
        $error("frame_draw_sched: invalid NUM_TILES/IDX_W/WD_CYCLES");
    end

    sched_state_t state;
    pix_src_t     src;
    logic         pending;
    logic         timeout;
    logic         aborted;

`ifdef FDS_WATCHDOG_EN
    localparam int WD_W = $clog2(WD_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;

    assign timeout = (wd_cnt == WD_W'(WD_CYCLES - 1));

    // The counter idles at zero outside CLEAR/TILE, so every pass starts from a fresh count.
    always_ff @(posedge clock) begin
        if (reset) begin
            wd_cnt  <= '0;
            aborted <= 1'b0;
            wd_err  <= 1'b0;
        end else begin
            if (state == ST_CLEAR || state == ST_TILE) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end else begin
                wd_cnt <= '0;
            end
            if (state == ST_IDLE) begin
                aborted <= 1'b0;
            end else if (timeout && ((state == ST_CLEAR && !clear_done) ||
                                     (state == ST_TILE && !tile_done))) begin
                aborted <= 1'b1;
                wd_err  <= 1'b1;
            end
        end
    end
`else
    assign timeout = 1'b0;
    assign aborted = 1'b0;
`endif

    always_comb begin
        src = SRC_NONE;
        case (state)
            ST_CLEAR: src = SRC_CLEAR;
            ST_TILE:  src = SRC_TILE;
            default:  src = SRC_NONE;
        endcase
    end

    // Outputs are set on the transition edge so they line up with the registered state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            clear_go   <= 1'b0;
            tile_go    <= 1'b0;
            tile_idx   <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            pending    <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (frame_tick && state != ST_IDLE) begin
                if (pending) overrun <= 1'b1;
                else         pending <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (frame_tick || pending) begin
                        state    <= ST_CLEAR;
                        clear_go <= 1'b1;
                        busy     <= 1'b1;
                        pending  <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (clear_done || timeout) begin
                        state    <= ST_CLR_REL;
                        clear_go <= 1'b0;
                    end
                end
                ST_CLR_REL: begin
                    tile_idx <= '0;
                    if (aborted) begin
                        state      <= ST_DONE;
                        frame_done <= 1'b1;
                    end else begin
                        state   <= ST_TILE;
                        tile_go <= 1'b1;
                    end
                end
                ST_TILE: begin
                    if (tile_done || timeout) begin
                        state   <= ST_TILE_REL;
                        tile_go <= 1'b0;
                    end
                end
                ST_TILE_REL: begin
                    if (aborted || tile_idx == LAST_IDX) begin
                        state      <= ST_DONE;
                        frame_done <= 1'b1;
                    end else begin
                        state    <= ST_TILE;
                        tile_go  <= 1'b1;
                        tile_idx <= tile_idx + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    fds_pixel_mux u_pixel_mux (
        .clock     (clock),
        .reset     (reset),
        .sel       (src),
        .clr_x     (clr_x),
        .clr_y     (clr_y),
        .clr_color (clr_color),
        .clr_en    (clr_en),
        .tl_x      (tl_x),
        .tl_y      (tl_y),
        .tl_color  (tl_color),
        .tl_en     (tl_en),
        .vga_x     (vga_x),
        .vga_y     (vga_y),
        .vga_color (vga_color),
        .vga_plot  (vga_plot)
    );

endmodule

// File: tb/tb_frame_draw_sched.sv
// Self-checking bench for frame_draw_sched with simple clear/tile engine models.
// Define FDS_WATCHDOG_EN to also exercise the watchdog with WD_CYCLES=100.
module tb_frame_draw_sched;
    import pianotiles_pkg::*;

    localparam int NUM_TILES = 4;
    localparam int IDX_W     = 4;

    logic                  clock, reset, frame_tick;
    logic                  clear_go, clear_done, clr_en;
    logic [SCREEN_X_W-1:0] clr_x, tl_x, vga_x;
    logic [SCREEN_Y_W-1:0] clr_y, tl_y, vga_y;
    logic [COLOR_W-1:0]    clr_color, tl_color, vga_color;
    logic                  tile_go, tile_done, tl_en, vga_plot;
    logic [IDX_W-1:0]      tile_idx;
    logic                  busy, frame_done, overrun;
`ifdef FDS_WATCHDOG_EN
    logic                  wd_err;
`endif

    int n_cmp = 0;
    int n_err = 0;

    frame_draw_sched #(
        .NUM_TILES (NUM_TILES),
`ifdef FDS_WATCHDOG_EN
        .WD_CYCLES (100),
`endif
        .IDX_W     (IDX_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .frame_tick (frame_tick),
        .clear_go   (clear_go),
        .clear_done (clear_done),
        .clr_x      (clr_x),
        .clr_y      (clr_y),
        .clr_color  (clr_color),
        .clr_en     (clr_en),
        .tile_go    (tile_go),
        .tile_idx   (tile_idx),
        .tile_done  (tile_done),
        .tl_x       (tl_x),
        .tl_y       (tl_y),
        .tl_color   (tl_color),
        .tl_en      (tl_en),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_color  (vga_color),
        .vga_plot   (vga_plot),
`ifdef FDS_WATCHDOG_EN
        .wd_err     (wd_err),
`endif
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Engine models: done asserts in the lat-th cycle of go (lat=1 means the same cycle go rises).
    int clr_lat = 40, tl_lat = 10, clr_cnt = 0, tl_cnt = 0;
    bit clr_never = 1'b0;
    always @(posedge clock) begin
        clr_cnt <= clear_go ? clr_cnt + 1 : 0;
        tl_cnt  <= tile_go ? tl_cnt + 1 : 0;
    end
    assign clear_done = clear_go && !clr_never && (clr_cnt >= clr_lat - 1);
    assign tile_done  = tile_go && (tl_cnt >= tl_lat - 1);

    typedef struct {
        logic                  tile_ph;
        logic                  c_en;
        logic [SCREEN_X_W-1:0] c_x;
        logic [SCREEN_Y_W-1:0] c_y;
        logic [COLOR_W-1:0]    c_col;
        logic                  t_en;
        logic [SCREEN_X_W-1:0] t_x;
        logic [SCREEN_Y_W-1:0] t_y;
        logic [COLOR_W-1:0]    t_col;
        logic [20:0]           exp_pix;
    } vec_t;

    vec_t vecs[7];
    logic [20:0] exp_q[$];

    task automatic step();
        @(negedge clock);
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return clear_go;
            1:       return tile_go;
            default: return frame_done;
        endcase
    endfunction

    task automatic wait_sig(input int which, input string name);
        int n = 0;
        while (sig(which) !== 1'b1 && n < 2000) begin
            step();
            n++;
        end
        check_output(name, 32'(sig(which)), 32'd1);
    endtask

    task automatic start_frame(input string name);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        check_output(name, 32'(clear_go), 32'd1);
    endtask

    task automatic apply_stimulus(input int i);
        clr_en = vecs[i].c_en; clr_x = vecs[i].c_x; clr_y = vecs[i].c_y; clr_color = vecs[i].c_col;
        tl_en  = vecs[i].t_en; tl_x  = vecs[i].t_x; tl_y  = vecs[i].t_y; tl_color  = vecs[i].t_col;
        exp_q.push_back(vecs[i].exp_pix);
        step();
        check_output($sformatf("pix_mux vec%0d", i), 32'({vga_plot, vga_x, vga_y, vga_color}),
                     32'(exp_q.pop_front()));
    endtask

    // Walks a whole frame from its first CLEAR cycle, checking pass lengths, gaps and tile order.
    task automatic run_frame(input int clr_exp, input int tl_exp, input string tag, output int len);
        int hi = 0;
        len = 0;
        while (clear_go === 1'b1 && hi < 5000) begin hi++; step(); end
        check_output({tag, " clear_go_len"}, 32'(hi), 32'(clr_exp));
        check_output({tag, " clr_rel_gap"}, 32'({tile_go, clear_go}), 32'd0);
        len = hi + 1;
        for (int k = 0; k < NUM_TILES; k++) begin
            step();
            check_output($sformatf("%s tile_go[%0d]", tag, k), 32'(tile_go), 32'd1);
            check_output($sformatf("%s tile_idx[%0d]", tag, k), 32'(tile_idx), 32'(k));
            hi = 0;
            while (tile_go === 1'b1 && hi < 5000) begin hi++; step(); end
            check_output($sformatf("%s tile_len[%0d]", tag, k), 32'(hi), 32'(tl_exp));
            len += hi + 1;
        end
        step();
        len++;
        check_output({tag, " frame_done"}, 32'({frame_done, busy}), 32'b11);
        step();
        check_output({tag, " idle_after"}, 32'({frame_done, busy}), 32'b00);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "[TB] simulation timed out");
    end

    initial begin
        int len, n;
        bit seen;

        vecs[0] = '{1'b0, 1'b1, 9'd120, 8'd5, 3'd7, 1'b1, 9'd300, 8'd200, 3'd2, {1'b1, 9'd120, 8'd5, 3'd7}};
        vecs[1] = '{1'b0, 1'b0, 9'd121, 8'd6, 3'd3, 1'b1, 9'd301, 8'd201, 3'd4, {1'b0, 9'd121, 8'd6, 3'd3}};
        vecs[2] = '{1'b0, 1'b1, 9'd319, 8'd239, 3'd0, 1'b0, 9'd0, 8'd0, 3'd1, {1'b1, 9'd319, 8'd239, 3'd0}};
        vecs[3] = '{1'b0, 1'b1, 9'd0, 8'd0, 3'd5, 1'b1, 9'd511, 8'd255, 3'd7, {1'b1, 9'd0, 8'd0, 3'd5}};
        vecs[4] = '{1'b1, 1'b1, 9'd10, 8'd10, 3'd1, 1'b1, 9'd64, 8'd120, 3'd6, {1'b1, 9'd64, 8'd120, 3'd6}};
        vecs[5] = '{1'b1, 1'b1, 9'd11, 8'd11, 3'd2, 1'b0, 9'd65, 8'd121, 3'd3, {1'b0, 9'd65, 8'd121, 3'd3}};
        vecs[6] = '{1'b1, 1'b0, 9'd12, 8'd12, 3'd4, 1'b1, 9'd511, 8'd255, COL_WHITE, {1'b1, 9'd511, 8'd255, 3'd7}};

        reset = 1'b1; frame_tick = 1'b0;
        clr_en = 1'b0; clr_x = '0; clr_y = '0; clr_color = '0;
        tl_en = 1'b0; tl_x = '0; tl_y = '0; tl_color = '0;
        repeat (3) step();
        reset = 1'b0;
        step();
        check_output("reset go/busy", 32'({clear_go, tile_go, busy, frame_done, overrun}), 32'd0);
        check_output("reset tile_idx", 32'(tile_idx), 32'd0);
        check_output("reset vga", 32'({vga_plot, vga_x, vga_y, vga_color}), 32'd0);
`ifdef FDS_WATCHDOG_EN
        check_output("reset wd_err", 32'(wd_err), 32'd0);
`endif

        $display("[TB] basic frame: clear 40, tiles 10");
        start_frame("t1 tick_to_go");
        run_frame(40, 10, "t1", len);

        $display("[TB] pixel mux vectors");
        clr_lat = 30; tl_lat = 20;
        start_frame("t2 tick_to_go");
        for (int i = 0; i < 7; i++) if (!vecs[i].tile_ph) apply_stimulus(i);
        clr_en = 1'b0; tl_en = 1'b0;
        wait_sig(1, "t2 wait tile_go");
        for (int i = 0; i < 7; i++) if (vecs[i].tile_ph) apply_stimulus(i);
        tl_en = 1'b0;
        wait_sig(2, "t2 wait frame_done");
        step();
        clr_en = 1'b1; clr_x = 9'd7; clr_y = 8'd7; clr_color = 3'd1;
        tl_en = 1'b1; tl_x = 9'd8; tl_y = 8'd8; tl_color = 3'd2;
        step();
        check_output("idle hold", 32'({vga_plot, vga_x, vga_y, vga_color}), 32'({1'b0, 9'd511, 8'd255, 3'd7}));
        clr_en = 1'b0; tl_en = 1'b0;

        $display("[TB] pending and overrun");
        clr_lat = 5; tl_lat = 2;
        start_frame("t3 tick_to_go");
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        check_output("t3 first tick no overrun", 32'(overrun), 32'd0);
        step();
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        check_output("t3 second tick overrun", 32'(overrun), 32'd1);
        wait_sig(2, "t3 wait frame_done");
        step();
        check_output("t3 idle gap", 32'({clear_go, busy}), 32'd0);
        step();
        check_output("t3 pending restart", 32'(clear_go), 32'd1);
        wait_sig(2, "t3 wait frame_done 2");
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        step();
        check_output("t3 done-cycle tick pending", 32'(clear_go), 32'd1);
        check_output("t3 overrun sticky", 32'(overrun), 32'd1);
        run_frame(5, 2, "t3", len);
        seen = 1'b0;
        repeat (3) begin step(); if (clear_go) seen = 1'b1; end
        check_output("t3 no stale pending", 32'(seen), 32'd0);

        $display("[TB] reset during tile 2");
        clr_lat = 5; tl_lat = 10;
        start_frame("t4 tick_to_go");
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        tl_en = 1'b1;
        n = 0;
        while (!(tile_go === 1'b1 && tile_idx == 4'd2) && n < 2000) begin step(); n++; end
        check_output("t4 reach tile 2", 32'({tile_go, tile_idx}), 32'({1'b1, 4'd2}));
        step();
        check_output("t4 plotting before reset", 32'(vga_plot), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0; tl_en = 1'b0;
        check_output("t4 reset outputs", 32'({tile_go, clear_go, vga_plot, busy, overrun}), 32'd0);
        check_output("t4 reset tile_idx", 32'(tile_idx), 32'd0);
        seen = 1'b0;
        repeat (3) begin step(); if (clear_go) seen = 1'b1; end
        check_output("t4 pending cleared", 32'(seen), 32'd0);

        $display("[TB] done in the same cycle as go");
        clr_lat = 3; tl_lat = 1;
        start_frame("t5 tick_to_go");
        run_frame(3, 1, "t5", len);
        check_output("t5 frame_len", 32'(len), 32'(3 + 2 * NUM_TILES + 2));

`ifdef FDS_WATCHDOG_EN
        $display("[TB] watchdog on a stuck clear engine");
        clr_never = 1'b1;
        start_frame("t6 tick_to_go");
        n = 0;
        while (clear_go === 1'b1 && n < 5000) begin n++; step(); end
        check_output("t6 clear_go_len", 32'(n), 32'd100);
        clr_never = 1'b0;
        check_output("t6 wd_err", 32'(wd_err), 32'd1);
        seen = 1'b0; n = 0;
        while (frame_done !== 1'b1 && n < 50) begin
            if (tile_go) seen = 1'b1;
            step(); n++;
        end
        check_output("t6 no tile_go", 32'(seen), 32'd0);
        check_output("t6 frame_done", 32'(frame_done), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
